// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI-style responder over an on-chip 64-bit SRAM (define AXI_SLAVE_ERR_EN for out-of-range SLVERR)
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          READ_LAT   = 1
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [63:0] RDATA,
    output logic        RLAST,
    output logic [1:0]  RRESP,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [63:0] WDATA,
    input  logic        WLAST,
    input  logic [3:0]  WUSER,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'(DEPTH) << 3;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

    r_state_t r_state;
    w_state_t w_state;

    logic [63:0]           mem [DEPTH];
    logic [31:0]           araddr_q, awaddr_q, r_off, w_off;
    logic [63:0]           wdata_q, w_shift;
    logic [3:0]            wuser_q, n_bytes, cnt;
    logic [DEPTH_LOG2-1:0] r_idx, w_idx;
    logic [7:0]            size_mask, strobe;
    logic [2:0]            b_off;
    logic                  r_oor, w_oor, w_cross, w_err, mem_we;
    logic                  unused_ok;

    assign r_off = araddr_q - BASE_ADDR;
    assign w_off = awaddr_q - BASE_ADDR;
    assign r_idx = r_off[DEPTH_LOG2+2:3];
    assign w_idx = w_off[DEPTH_LOG2+2:3];

`ifdef AXI_SLAVE_ERR_EN
    assign r_oor = r_off >= SPAN;
    assign w_oor = w_off >= SPAN;
`else
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
`endif

    assign size_mask = wuser_q == 4'b0001 ? 8'h01 : wuser_q == 4'b0010 ? 8'h03 : wuser_q == 4'b0100 ? 8'h0F : 8'hFF;
    assign n_bytes   = wuser_q == 4'b0001 ? 4'd1 : wuser_q == 4'b0010 ? 4'd2 : wuser_q == 4'b0100 ? 4'd4 : 4'd8;
    assign b_off     = awaddr_q[2:0];
    assign w_cross   = {1'b0, b_off} + n_bytes > 4'd8;
    assign strobe    = size_mask << b_off;
    assign w_shift   = wdata_q << {b_off, 3'b000};
    assign w_err     = w_cross | w_oor;
    assign mem_we    = w_state == W_COMMIT && !w_err;
    assign RLAST     = RVALID;
    assign unused_ok = ^{ARPROT, AWPROT, WLAST, r_off, w_off};

    // Byte-lane SRAM write during the single commit cycle
    always_ff @(posedge ACLK)
        if (mem_we)
            for (int b = 0; b < 8; b++)
                if (strobe[b]) mem[w_idx][8*b +: 8] <= w_shift[8*b +: 8];

    // Read channel: accept address, count down the latency, present one beat until taken
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            r_state  <= R_IDLE;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= 2'b00;
            cnt      <= '0;
            araddr_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID && ARREADY) begin
                    araddr_q <= ARADDR;
                    ARREADY  <= 1'b0;
                    cnt      <= 4'(READ_LAT);
                    r_state  <= R_WAIT;
                end
                R_WAIT: if (cnt == 4'd0) begin
                    RDATA   <= r_oor ? '0 : mem[r_idx];
                    RRESP   <= r_oor ? 2'b10 : 2'b00;
                    RVALID  <= 1'b1;
                    r_state <= R_DATA;
                end else cnt <= cnt - 4'd1;
                R_DATA: if (RREADY) begin
                    RVALID  <= 1'b0;
                    ARREADY <= 1'b1;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end

    // Write channel: collect AW and W in any order, commit once both are held, then respond
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            w_state  <= W_IDLE;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            BVALID   <= 1'b0;
            BRESP    <= 2'b00;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wuser_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        awaddr_q <= AWADDR;
                        AWREADY  <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        wdata_q <= WDATA;
                        wuser_q <= WUSER;
                        WREADY  <= 1'b0;
                    end
                    if (!AWREADY && !WREADY) w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    BVALID  <= 1'b1;
                    BRESP   <= w_err ? 2'b10 : 2'b00;
                    w_state <= W_RESP;
                end
                W_RESP: if (BREADY) begin
                    BVALID  <= 1'b0;
                    AWREADY <= 1'b1;
                    WREADY  <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: vector table, handshake/latency sequences and randomized traffic against a byte-level memory model
module tb_axi_sram_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int DL = 4, RL = 3, LIM = 64, WORDS = 16;

    logic        ACLK, ARESETn;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [31:0] ARADDR, AWADDR;
    logic [2:0]  ARPROT, AWPROT;
    logic [63:0] RDATA, WDATA;
    logic [1:0]  RRESP, BRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [3:0]  WUSER;

    int checks = 0, errors = 0;
    logic [63:0] model [WORDS];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wuser;
        logic [1:0]  bresp;
        logic [63:0] rdata;
    } vec_t;
    vec_t vecs [10];

    axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL), .READ_LAT(RL)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST), .WUSER(WUSER),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [3:0] u, output logic [1:0] resp);
        int n;
        logic aw_hs, w_hs;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WUSER = u; WLAST = 1'b1;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        n = 0;
        while ((AWVALID || WVALID) && n < LIM) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs) WVALID = 1'b0;
            n++;
        end
        while (!BVALID && n < LIM) begin
            @(negedge ACLK);
            n++;
        end
        chk("wr_timeout", 64'(n >= LIM), 64'd0);
        resp = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        n = 0;
        while (!ARREADY && n < LIM) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        while (!RVALID && n < LIM) begin
            @(negedge ACLK);
            n++;
        end
        chk("rd_timeout", 64'(n >= LIM), 64'd0);
        chk("rd_rlast", 64'(RLAST), 64'd1);
        d = RDATA;
        resp = RRESP;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    // Reference: bytes written one at a time into an aliased word array
    task automatic model_wr(input logic [31:0] a, input logic [63:0] d, input logic [3:0] u, output logic [1:0] resp);
        int n, off, idx;
        n   = u == 4'b0001 ? 1 : u == 4'b0010 ? 2 : u == 4'b0100 ? 4 : 8;
        off = int'(a[2:0]);
        idx = int'((a - BASE) / 8) % WORDS;
        if (off + n > 8) resp = 2'b10;
        else begin
            resp = 2'b00;
            for (int i = 0; i < n; i++) model[idx][8*(off+i) +: 8] = d[8*i +: 8];
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  r, er;
        logic [31:0] a;
        logic [3:0]  u;
        logic [3:0]  users [7];
        int lat;
        vecs[0] = '{32'h8000_0000, 64'h0123456789ABCDEF, 4'b1000, 2'b00, 64'h0123456789ABCDEF};
        vecs[1] = '{32'h8000_0010, 64'h1122334455667788, 4'b1000, 2'b00, 64'h1122334455667788};
        vecs[2] = '{32'h8000_0013, 64'h00000000000000AB, 4'b0001, 2'b00, 64'h11223344AB667788};
        vecs[3] = '{32'h8000_0006, 64'h00000000DEADBEEF, 4'b0100, 2'b10, 64'h0123456789ABCDEF};
        vecs[4] = '{32'h8000_0016, 64'h000000000000BEEF, 4'b0010, 2'b00, 64'hBEEF3344AB667788};
        vecs[5] = '{32'h8000_0014, 64'h00000000CAFEF00D, 4'b0100, 2'b00, 64'hCAFEF00DAB667788};
        vecs[6] = '{32'h8000_0017, 64'h0000000000001234, 4'b0010, 2'b10, 64'hCAFEF00DAB667788};
        vecs[7] = '{32'h8000_0018, 64'hFEDCBA9876543210, 4'b0011, 2'b00, 64'hFEDCBA9876543210};
        vecs[8] = '{32'h8000_0019, 64'hFFFFFFFFFFFFFF5A, 4'b0001, 2'b00, 64'hFEDCBA9876545A10};
        vecs[9] = '{32'h8000_0019, 64'h1111111111111111, 4'b1000, 2'b10, 64'hFEDCBA9876545A10};
        users = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000, 4'b1111};

        ARESETn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; AWADDR = '0; WDATA = '0; WUSER = '0; WLAST = 1'b1; ARPROT = '0; AWPROT = '0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rst_arready", 64'(ARREADY), 64'd1);
        chk("rst_awready", 64'(AWREADY), 64'd1);
        chk("rst_wready", 64'(WREADY), 64'd1);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);

        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].wdata, vecs[i].wuser, r);
            chk($sformatf("vec%0d_bresp", i), 64'(r), 64'(vecs[i].bresp));
            rd(vecs[i].addr, d, r);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            chk($sformatf("vec%0d_rresp", i), 64'(r), 64'd0);
        end

        // W beat three cycles ahead of AW, response held under BREADY low
        @(negedge ACLK);
        WDATA = 64'h0F1E2D3C4B5A6978; WUSER = 4'b1000; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        WVALID = 1'b0;
        chk("wfirst_wready", 64'(WREADY), 64'd0);
        chk("wfirst_awready", 64'(AWREADY), 64'd1);
        repeat (2) @(negedge ACLK);
        AWADDR = 32'h8000_0020; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("wfirst_awready_low", 64'(AWREADY), 64'd0);
        lat = 0;
        while (!BVALID && lat < LIM) begin
            @(negedge ACLK);
            lat++;
        end
        chk("aw_to_bvalid_latency", 64'(lat), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("bhold_bvalid", 64'(BVALID), 64'd1);
            chk("bhold_ready", 64'({AWREADY, WREADY}), 64'd0);
            @(negedge ACLK);
        end
        chk("bhold_bresp", 64'(BRESP), 64'd0);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("bdone_bvalid", 64'(BVALID), 64'd0);
        chk("bdone_ready", 64'({AWREADY, WREADY}), 64'd3);
        rd(32'h8000_0020, d, r);
        chk("wfirst_readback", d, 64'h0F1E2D3C4B5A6978);

        // Read latency READ_LAT+1 and RDATA held while RREADY low
        @(negedge ACLK);
        chk("lat_arready", 64'(ARREADY), 64'd1);
        ARADDR = 32'h8000_0010; ARVALID = 1'b1; RREADY = 1'b0;
        @(negedge ACLK);
        ARVALID = 1'b0;
        lat = 0;
        while (!RVALID && lat < LIM) begin
            @(negedge ACLK);
            lat++;
        end
        chk("ar_to_rvalid_latency", 64'(lat), 64'(RL + 1));
        chk("lat_rdata", RDATA, 64'hCAFEF00DAB667788);
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            chk("rhold_rvalid", 64'(RVALID), 64'd1);
            chk("rhold_rdata", RDATA, 64'hCAFEF00DAB667788);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        chk("rdone_rvalid", 64'(RVALID), 64'd0);
        chk("rdone_arready", 64'(ARREADY), 64'd1);

        // Asynchronous reset while the read is waiting
        @(negedge ACLK);
        ARADDR = 32'h8000_0000; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        @(negedge ACLK);
        chk("rwait_arready", 64'(ARREADY), 64'd0);
        ARESETn = 1'b0;
        #1;
        chk("arst_rvalid", 64'(RVALID), 64'd0);
        chk("arst_arready", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARESETn = 1'b1;
        rd(32'h8000_0000, d, r);
        chk("post_rst_rdata", d, 64'h0123456789ABCDEF);

        // Out-of-range accesses: SLVERR with the error check, aliasing without
`ifdef AXI_SLAVE_ERR_EN
        er = 2'b10;
`else
        er = 2'b00;
`endif
        wr(32'h8000_0080, 64'h7777777777777777, 4'b1000, r);
        chk("oor_bresp", 64'(r), 64'(er));
        rd(32'h8000_0000, d, r);
        chk("oor_alias_word0", d, er == 2'b10 ? 64'h0123456789ABCDEF : 64'h7777777777777777);
        wr(32'h8000_0078, 64'h5555AAAA3333CCCC, 4'b1000, r);
        chk("last_word_bresp", 64'(r), 64'd0);
        rd(32'h7FFF_FFF8, d, r);
        chk("below_base_rresp", 64'(r), 64'(er));
        chk("below_base_rdata", d, er == 2'b10 ? 64'd0 : 64'h5555AAAA3333CCCC);

        // Randomized traffic against the reference model
        for (int i = 0; i < WORDS; i++) begin
            d = {$urandom, $urandom};
            a = BASE + 32'(8 * i);
            model_wr(a, d, 4'b1000, er);
            wr(a, d, 4'b1000, r);
            chk("init_bresp", 64'(r), 64'(er));
        end
        for (int i = 0; i < 300; i++) begin
            a = BASE + 32'($urandom_range(8 * WORDS - 1, 0));
            if ($urandom_range(1, 0) == 1) begin
                u = users[$urandom_range(6, 0)];
                d = {$urandom, $urandom};
                model_wr(a, d, u, er);
                wr(a, d, u, r);
                chk($sformatf("rand_bresp a=%h u=%b", a, u), 64'(r), 64'(er));
            end else begin
                rd(a, d, r);
                chk($sformatf("rand_rdata a=%h", a), d, model[((a - BASE) / 8) % WORDS]);
                chk("rand_rresp", 64'(r), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
